// File: rtl/weight_skew_feeder_pkg.sv
// rtl/weight_skew_feeder_pkg.sv - shared array configuration, feeder FSM states and weight word type
package weight_skew_feeder_pkg;

    localparam int sys_cols   = 4;
    localparam int W_BITWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } wsf_state_t;

    typedef logic [W_BITWIDTH-1:0] weight_t;

    // Index width that stays legal for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_skew_feeder_col_bank.sv
// rtl/weight_skew_feeder_col_bank.sv - one column's weight RAM: 1W1R, read-first, registered read
module wsf_col_bank #(
    parameter  int DEPTH = 64,
    parameter  int W_BW  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [W_BW-1:0] wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [W_BW-1:0] rdata_o
);

    logic [W_BW-1:0] mem_q [DEPTH];
    logic [W_BW-1:0] rdata_q;

    // Contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_skew_feeder.sv
// rtl/weight_skew_feeder.sv - RAM-loaded, diagonally skewed weight feeder for the systolic array top edge
// Optional WSF_ZERO_GATE_EN: drive zero weights on columns whose valid is low.
module weight_skew_feeder
    import weight_skew_feeder_pkg::*;
#(
    parameter  int N_COLS = sys_cols,
    parameter  int W_BW   = W_BITWIDTH,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = clog2_min1(N_COLS)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   wr_en,
    input  logic [CW-1:0]          wr_col,
    input  logic [AW-1:0]          wr_addr,
    input  logic [W_BW-1:0]        wr_data,
    input  logic                   start,
    input  logic [AW-1:0]          rd_base,
    input  logic [AW:0]            len,
    output logic                   busy,
    output logic                   done,
    output logic [N_COLS-1:0]      o_valid,
    output logic [N_COLS*W_BW-1:0] o_data
);

    wsf_state_t      state_q, state_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW:0]     len_q, len_d;
    logic [AW:0]     row_cnt_q, row_cnt_d;
    logic [AW:0]     len_eff;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            zero_pend_q, zero_pend_d;

    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic [N_COLS-1:0] iss_en_q;
    logic [AW-1:0]   iss_addr_q [N_COLS];
    logic [N_COLS-1:0] val_q;
    logic [W_BW-1:0] col_rdata [N_COLS];

    assign len_eff = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            base_q      <= '0;
            len_q       <= '0;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        zero_pend_d = zero_pend_q;
        issue_en    = 1'b0;
        issue_addr  = base_q + row_cnt_q[AW-1:0];

        case (state_q)
            IDLE: begin
                // An empty tile stays in IDLE but still owes one busy cycle and a done pulse.
                if (zero_pend_q) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    zero_pend_d = 1'b0;
                end else if (start) begin
                    base_d    = rd_base;
                    len_d     = len_eff;
                    row_cnt_d = '0;
                    busy_d    = 1'b1;
                    if (len_eff == '0) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                issue_en  = 1'b1;
                row_cnt_d = row_cnt_q + (AW+1)'(1);
                if (row_cnt_q == len_q - (AW+1)'(1)) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + CW'(1);
                if (drain_cnt_q == CW'(N_COLS - 1)) begin
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    drain_cnt_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Stage j of this chain is column j's read request, giving the diagonal skew.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            iss_en_q <= '0;
            val_q    <= '0;
            for (int j = 0; j < N_COLS; j++) begin
                iss_addr_q[j] <= '0;
            end
        end else begin
            iss_en_q[0]   <= issue_en;
            iss_addr_q[0] <= issue_addr;
            for (int j = 1; j < N_COLS; j++) begin
                iss_en_q[j]   <= iss_en_q[j-1];
                iss_addr_q[j] <= iss_addr_q[j-1];
            end
            val_q <= iss_en_q;
        end
    end

    for (genvar j = 0; j < N_COLS; j++) begin : g_col
        wsf_col_bank #(
            .DEPTH (DEPTH),
            .W_BW  (W_BW)
        ) u_bank (
            .clk     (clk),
            .rstn    (rstn),
            .we_i    (wr_en && (wr_col == CW'(j))),
            .waddr_i (wr_addr),
            .wdata_i (wr_data),
            .re_i    (iss_en_q[j]),
            .raddr_i (iss_addr_q[j]),
            .rdata_o (col_rdata[j])
        );
`ifdef WSF_ZERO_GATE_EN
        assign o_data[j*W_BW +: W_BW] = val_q[j] ? col_rdata[j] : '0;
`else
        assign o_data[j*W_BW +: W_BW] = col_rdata[j];
`endif
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign o_valid = val_q;

endmodule
